// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared types and constants for the 7-segment scan controller.
// Contents: FSM state enum, per-digit slot record, blank pattern, digit count.
// Used by seg_scan_ctrl_if, hex7seg and seg_scan_ctrl.
package seg_scan_pkg;

  localparam int          NDIG      = 8;
  localparam logic [7:0]  SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    CLEAR,
    WAIT,
    LOAD
  } state_t;

  typedef struct packed {
    logic       on;
    logic       dp;
    logic [3:0] val;
  } slot_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: digit-update port, valid/ready handshake.
// master (writer) drives wr_valid/wr_idx/wr_val/wr_on/wr_dp; slave drives wr_ready.
// Payload must be held by the master until wr_valid && wr_ready is seen at a clock edge.
interface seg_scan_ctrl_if
  import seg_scan_pkg::*;
;
  logic                        wr_valid;
  logic                        wr_ready;
  logic [$clog2(NDIG)-1:0]     wr_idx;
  logic [3:0]                  wr_val;
  logic                        wr_on;
  logic                        wr_dp;

  modport master (
    output wr_valid, wr_idx, wr_val, wr_on, wr_dp,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_idx, wr_val, wr_on, wr_dp,
    output wr_ready
  );
endinterface

// File: rtl/seg_scan_ctrl_hex7seg.sv
// hex7seg: hex value to active-low 7-segment pattern ([7]=a .. [1]=g, [0]=dp).
// Latency: purely combinational. Backpressure: none.
// Ports: val (4b hex), on (0 = blank), dp (1 = light decimal point) -> seg (8b).
module hex7seg
  import seg_scan_pkg::*;
(
  input  logic [3:0] val,
  input  logic       on,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] glyph;

  always_comb begin
    glyph = SEG_BLANK;
    case (val)
      4'h0: glyph = 8'h03;
      4'h1: glyph = 8'h9F;
      4'h2: glyph = 8'h25;
      4'h3: glyph = 8'h0D;
      4'h4: glyph = 8'h99;
      4'h5: glyph = 8'h49;
      4'h6: glyph = 8'h41;
      4'h7: glyph = 8'h1F;
      4'h8: glyph = 8'h01;
      4'h9: glyph = 8'h09;
      4'hA: glyph = 8'h11;
      4'hB: glyph = 8'hC1;
      4'hC: glyph = 8'h63;
      4'hD: glyph = 8'h85;
      4'hE: glyph = 8'h61;
      4'hF: glyph = 8'h71;
      default: glyph = SEG_BLANK;
    endcase
  end

  always_comb begin
    seg = SEG_BLANK;
    if (on) begin
      seg    = glyph;
      // Every glyph leaves dp dark (bit 0 = 1), so lighting it is a single clear.
      seg[0] = glyph[0] & ~dp;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: owns seg0..seg7, time-slices one hex7seg decoder round-robin over
// the eight digit slots; each slot is re-latched once every SCAN_DIV cycles.
// Latency: accepted write visible on its seg within 8*SCAN_DIV+1 cycles.
// Backpressure: wr_ready is low only while the CLEAR walk runs after reset.
// Ports: clk, rst (sync, active-low), wr_bus (slave update port), seg0..seg7
// (active-low pins), scan_idx (digit being refreshed), round_done (pulse after digit 7).
// Optional: `define SEG_SCAN_BLINK_EN adds blink_mask[7:0] and the BLINK_ROUNDS phase.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int SCAN_DIV = 1000
`ifdef SEG_SCAN_BLINK_EN
  ,
  parameter int BLINK_ROUNDS = 64
`endif
) (
  input  logic              clk,
  input  logic              rst,
  seg_scan_ctrl_if.slave    wr_bus,
`ifdef SEG_SCAN_BLINK_EN
  input  logic [NDIG-1:0]   blink_mask,
`endif
  output logic [7:0]        seg0,
  output logic [7:0]        seg1,
  output logic [7:0]        seg2,
  output logic [7:0]        seg3,
  output logic [7:0]        seg4,
  output logic [7:0]        seg5,
  output logic [7:0]        seg6,
  output logic [7:0]        seg7,
  output logic [2:0]        scan_idx,
  output logic              round_done
);

  localparam int                 PTR_W    = $clog2(NDIG);
  localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(NDIG - 1);
  localparam int                 DIV_W    = $clog2(SCAN_DIV);
  // WAIT spends SCAN_DIV-1 cycles (div = 0..SCAN_DIV-2) and LOAD one more.
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(SCAN_DIV - 2);

  state_t            state;
  state_t            state_nxt;
  logic [PTR_W-1:0]  ptr;
  logic [DIV_W-1:0]  div;
  slot_t             slots [NDIG];
  logic [7:0]        segs  [NDIG];
  slot_t             cur;
  logic [7:0]        dec_seg;
  logic [7:0]        load_seg;
  logic              ready;

  // The single shared decoder always looks at the slot under the pointer.
  assign cur = slots[ptr];

  hex7seg u_dec (
    .val (cur.val),
    .on  (cur.on),
    .dp  (cur.dp),
    .seg (dec_seg)
  );

`ifdef SEG_SCAN_BLINK_EN
  localparam int                RC_W    = $clog2(BLINK_ROUNDS + 1);
  localparam logic [RC_W-1:0]   RC_LAST = RC_W'(BLINK_ROUNDS - 1);

  logic            phase;
  logic [RC_W-1:0] rcnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase <= 1'b0;
      rcnt  <= '0;
    end else if (round_done) begin
      if (rcnt == RC_LAST) begin
        rcnt  <= '0;
        phase <= ~phase;
      end else begin
        rcnt  <= rcnt + 1'b1;
      end
    end
  end

  assign load_seg = (phase && blink_mask[ptr]) ? SEG_BLANK : dec_seg;
`else
  assign load_seg = dec_seg;
`endif

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      CLEAR: begin
        if (ptr == PTR_LAST) state_nxt = WAIT;
      end
      WAIT: begin
        ready = 1'b1;
        if (div == DIV_LAST) state_nxt = LOAD;
      end
      LOAD: begin
        ready     = 1'b1;
        state_nxt = WAIT;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  assign wr_bus.wr_ready = ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= CLEAR;
      ptr        <= '0;
      div        <= '0;
      round_done <= 1'b0;
      for (int k = 0; k < NDIG; k++) begin
        slots[k] <= '0;
        segs[k]  <= SEG_BLANK;
      end
    end else begin
      state      <= state_nxt;
      round_done <= (state == LOAD) && (ptr == PTR_LAST);
      case (state)
        CLEAR: begin
          segs[ptr] <= SEG_BLANK;
          ptr       <= ptr + 1'b1;
          div       <= '0;
        end
        WAIT: begin
          div <= div + 1'b1;
        end
        LOAD: begin
          segs[ptr] <= load_seg;
          ptr       <= ptr + 1'b1;
          div       <= '0;
        end
        default: ;
      endcase
      // Nonblocking: a same-edge LOAD of this slot latches the old contents.
      if (wr_bus.wr_valid && ready)
        slots[wr_bus.wr_idx] <= {wr_bus.wr_on, wr_bus.wr_dp, wr_bus.wr_val};
    end
  end

  assign scan_idx = ptr;
  assign seg0 = segs[0];
  assign seg1 = segs[1];
  assign seg2 = segs[2];
  assign seg3 = segs[3];
  assign seg4 = segs[4];
  assign seg5 = segs[5];
  assign seg6 = segs[6];
  assign seg7 = segs[7];

endmodule
